// File: rtl/psram_rx_deser_if.sv
// Word-side handshake bundle of the PSRAM read deserializer.
// The master drives valid/data/be/last; the slave drives ready.
interface psram_rx_deser_if;
    logic        valid;
    logic        ready;
    logic [63:0] data;
    logic [7:0]  be;
    logic        last;

    modport master (output valid, data, be, last, input ready);
    modport slave  (input valid, data, be, last, output ready);
endinterface

// File: rtl/psram_rx_deser.sv
// PSRAM read-data deserializer: packs strobed bytes little-endian into 64-bit words,
// buffers them in a small FIFO and offers them over a valid/ready handshake.
//
//  state | meaning
//  IDLE  | no burst in progress; samples and last are ignored
//  RECV  | burst active; bytes accumulate in the shadow register
module psram_rx_deser #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic                          start_i,
    input  logic                          sample_i,
    input  logic [7:0]                    io_in_i,
    input  logic                          last_i,
    psram_rx_deser_if.master              rx,
    output logic [$clog2(FIFO_DEPTH):0]   cnt_o,
    output logic                          busy_o,
    output logic                          ovf_o,
    input  logic                          clr_ovf_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    typedef enum logic {IDLE, RECV} state_t;

    state_t      state;
    logic [63:0] shadow;
    logic [7:0]  be_acc;
    logic [2:0]  idx;

    logic        in_recv, restart, active, smp, full_word, flush, push;
    logic [63:0] base_data, nxt_data;
    logic [7:0]  base_be, nxt_be;
    logic [2:0]  base_idx;

    logic [72:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop, push_ok, drop;

    // last_i outranks start_i, so a coincident start neither clears nor opens a burst
    always_comb begin
        in_recv   = (state == RECV);
        restart   = en_i & start_i & ~last_i;
        active    = en_i & (in_recv | restart);
        smp       = active & sample_i;
        flush     = en_i & last_i & in_recv;
        base_data = restart ? 64'd0 : shadow;
        base_be   = restart ? 8'd0  : be_acc;
        base_idx  = restart ? 3'd0  : idx;
        nxt_data  = base_data;
        nxt_be    = base_be;
        for (int k = 0; k < 8; k++) begin
            if (smp && base_idx == 3'(k)) begin
                nxt_data[8*k +: 8] = io_in_i;
                nxt_be[k]          = 1'b1;
            end
        end
        full_word = smp & (base_idx == 3'd7);
        push      = full_word | flush;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            shadow <= '0;
            be_acc <= '0;
            idx    <= '0;
        end else begin
            if (flush) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end else if (restart) begin
                state  <= RECV;
                busy_o <= 1'b1;
            end
            if (push) begin
                shadow <= '0;
                be_acc <= '0;
                idx    <= '0;
            end else if (smp) begin
                shadow <= nxt_data;
                be_acc <= nxt_be;
                idx    <= base_idx + 3'd1;
            end else if (restart) begin
                shadow <= '0;
                be_acc <= '0;
                idx    <= '0;
            end
        end
    end

    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
    always_comb begin
        pop     = rx.valid & rx.ready;
        push_ok = push & ((cnt_o < DEPTH_C) | pop);
        drop    = push & ~push_ok;
    end

    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem[wr_ptr] <= {flush, nxt_be, nxt_data};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_o  <= '0;
            ovf_o  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   cnt_o <= cnt_o + 1'b1;
                2'b01:   cnt_o <= cnt_o - 1'b1;
                default: cnt_o <= cnt_o;
            endcase
            if (drop)           ovf_o <= 1'b1;
            else if (clr_ovf_i) ovf_o <= 1'b0;
        end
    end

    // Head fields read as zero when empty so stale entries never leak out
    always_comb begin
        rx.valid = (cnt_o != '0);
        rx.data  = rx.valid ? mem[rd_ptr][63:0]  : 64'd0;
        rx.be    = rx.valid ? mem[rd_ptr][71:64] : 8'd0;
        rx.last  = rx.valid ? mem[rd_ptr][72]    : 1'b0;
    end
endmodule

// File: tb/tb_psram_rx_deser.sv
// Scoreboard bench for psram_rx_deser: directed bursts push expected words,
// a negedge monitor pops and compares every word handed over.
module tb_psram_rx_deser;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  be;
        logic        l;
    } word_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1, start = 1'b0, sample = 1'b0, last = 1'b0, clr_ovf = 1'b0;
    logic [7:0] io_in = 8'd0;
    logic [2:0] cnt;
    logic       busy, ovf;

    psram_rx_deser_if rx ();

    psram_rx_deser #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .start_i   (start),
        .sample_i  (sample),
        .io_in_i   (io_in),
        .last_i    (last),
        .rx        (rx),
        .cnt_o     (cnt),
        .busy_o    (busy),
        .ovf_o     (ovf),
        .clr_ovf_i (clr_ovf)
    );

    always #5 clk = ~clk;

    word_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx.valid === 1'b1 && rx.ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got %h be %h last %b, expected none",
                         rx.data, rx.be, rx.last);
            end else begin
                word_t e;
                e = exp_q.pop_front();
                chk("word_data", rx.data, e.d);
                chk("word_be", 64'(rx.be), 64'(e.be));
                chk("word_last", 64'(rx.last), 64'(e.l));
            end
        end
    end

    task automatic step(input logic s, input logic smp, input logic [7:0] b, input logic l);
        start  = s;
        sample = smp;
        io_in  = b;
        last   = l;
        @(posedge clk);
        #1;
        start  = 1'b0;
        sample = 1'b0;
        last   = 1'b0;
    endtask

    task automatic expect_word(input logic [63:0] d, input logic [7:0] be, input logic l);
        word_t w;
        w.d  = d;
        w.be = be;
        w.l  = l;
        exp_q.push_back(w);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        rx.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_valid", 64'(rx.valid), 64'd0);
        chk("reset_data", rx.data, 64'd0);
        chk("reset_cnt", 64'(cnt), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);

        // full word, last on the 8th byte
        step(1, 0, 8'h00, 0);
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) expect_word(64'h8877665544332211, 8'hFF, 1'b1);
            step(0, 1, 8'(k * 8'h11), k == 8);
        end
        chk("busy_after_last", 64'(busy), 64'd0);
        drain("full_word_drain");
        chk("full_word_ovf", 64'(ovf), 64'd0);

        // partial flush
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'hA1, 0);
        step(0, 1, 8'hB2, 0);
        step(0, 1, 8'hC3, 0);
        expect_word(64'h0000_0000_00C3_B2A1, 8'h07, 1'b1);
        step(0, 0, 8'h00, 1);
        drain("partial_drain");

        // empty terminator after a full word
        step(1, 0, 8'h00, 0);
        expect_word(64'h0807060504030201, 8'hFF, 1'b0);
        for (int k = 1; k <= 8; k++) step(0, 1, 8'(k), 0);
        expect_word(64'd0, 8'h00, 1'b1);
        step(0, 0, 8'h00, 1);
        drain("terminator_drain");

        // backpressure: five words into a four-deep FIFO
        rx.ready = 1'b0;
        step(1, 0, 8'h00, 0);
        for (int w = 0; w < 5; w++) begin
            d = '0;
            for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(w * 16 + k);
            if (w < 4) expect_word(d, 8'hFF, 1'b0);
            for (int k = 0; k < 8; k++) step(0, 1, 8'(w * 16 + k), (w == 4) && (k == 7));
        end
        chk("ovf_cnt", 64'(cnt), 64'd4);
        chk("ovf_set", 64'(ovf), 64'd1);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        chk("ovf_cleared", 64'(ovf), 64'd0);

        // full FIFO: push and pop on the same edge
        step(1, 0, 8'h00, 0);
        for (int k = 0; k < 7; k++) step(0, 1, 8'(8'hE0 + k), 0);
        expect_word(64'hE7E6E5E4E3E2E1E0, 8'hFF, 1'b1);
        rx.ready = 1'b1;
        step(0, 1, 8'hE7, 1);
        rx.ready = 1'b0;
        chk("simul_cnt", 64'(cnt), 64'd4);
        chk("simul_ovf", 64'(ovf), 64'd0);
        rx.ready = 1'b1;
        drain("backpressure_drain");

        // restart with a coincident sample
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h01, 0);
        step(0, 1, 8'h02, 0);
        step(0, 1, 8'h03, 0);
        step(1, 1, 8'h5A, 0);
        expect_word(64'h5A, 8'h01, 1'b1);
        step(0, 0, 8'h00, 1);
        drain("restart_drain");

        // enable low: samples and last are ignored
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h11, 0);
        en = 1'b0;
        step(0, 1, 8'h22, 0);
        step(0, 1, 8'h33, 1);
        chk("en_low_busy", 64'(busy), 64'd1);
        en = 1'b1;
        step(0, 1, 8'h44, 0);
        expect_word(64'h4411, 8'h03, 1'b1);
        step(0, 0, 8'h00, 1);
        drain("enable_drain");

        // reset mid-burst with a full, overflowed FIFO
        rx.ready = 1'b0;
        step(1, 0, 8'h00, 0);
        for (int k = 0; k < 43; k++) step(0, 1, 8'(k), 0);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        chk("pre_rst_ovf", 64'(ovf), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", 64'(rx.valid), 64'd0);
        chk("rst_data", rx.data, 64'd0);
        chk("rst_be", 64'(rx.be), 64'd0);
        chk("rst_last", 64'(rx.last), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
